// File: rtl/video_timing_gen_if.sv
// Video output bundle from the timing generator to the TMDS encoder stage.
// The generator drives it through the master modport.
interface video_timing_gen_if;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [10:0] x;
  logic [10:0] y;
  logic        new_line;
  logic        new_frame;
  logic [23:0] pixel;

  modport master (output de, hsync, vsync, x, y, new_line, new_frame, pixel);
  modport slave  (input  de, hsync, vsync, x, y, new_line, new_frame, pixel);
endinterface

// File: rtl/video_timing_gen.sv
// Pixel-clock raster timing and test-pattern generator.
// All outputs are registered from the counter state of the previous cycle.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk_px,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  video_timing_gen_if.master vid
);

  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT        = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int          BAR_W        = H_ACTIVE / 8;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  pattern_q, pattern_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        new_line_q, new_line_d;
  logic        new_frame_q, new_frame_d;
  logic [23:0] pixel_q, pixel_d;

  logic        frame_start;
  logic        active;
  logic [1:0]  pattern_cur;
  logic [2:0]  bar;
  logic [23:0] pattern_pixel;

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= 11'(i * BAR_W)) bar = 3'(i);
    end
  end

  // The pattern is taken straight from pattern_sel on the first pixel so the whole frame agrees.
  always_comb begin
    frame_start   = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    pattern_cur   = frame_start ? pattern_sel : pattern_q;
    pattern_pixel = 24'h000000;
    case (pattern_cur)
      2'd0: begin
        case (bar)
          3'd0:    pattern_pixel = 24'hFFFFFF;
          3'd1:    pattern_pixel = 24'hFFFF00;
          3'd2:    pattern_pixel = 24'h00FFFF;
          3'd3:    pattern_pixel = 24'h00FF00;
          3'd4:    pattern_pixel = 24'hFF00FF;
          3'd5:    pattern_pixel = 24'hFF0000;
          3'd6:    pattern_pixel = 24'h0000FF;
          default: pattern_pixel = 24'h000000;
        endcase
      end
      2'd1:    pattern_pixel = {h_cnt_q[7:0], v_cnt_q[7:0], h_cnt_q[7:0] ^ v_cnt_q[7:0]};
      2'd2:    pattern_pixel = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
      default: pattern_pixel = {16'h0000, frame_cnt_q};
    endcase
  end

  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pattern_d   = pattern_q;
    de_d        = 1'b0;
    hsync_d     = ~SYNC_POL;
    vsync_d     = ~SYNC_POL;
    x_d         = 11'd0;
    y_d         = 11'd0;
    new_line_d  = 1'b0;
    new_frame_d = 1'b0;
    pixel_d     = 24'h000000;
    if (!enable) begin
      h_cnt_d     = 11'd0;
      v_cnt_d     = 11'd0;
      frame_cnt_d = 8'd0;
    end else begin
      pattern_d   = pattern_cur;
      new_frame_d = frame_start;
      if (active) begin
        de_d       = 1'b1;
        x_d        = h_cnt_q;
        y_d        = v_cnt_q;
        pixel_d    = pattern_pixel;
        new_line_d = (h_cnt_q == 11'd0);
      end
      if ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) hsync_d = SYNC_POL;
      if ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) vsync_d = SYNC_POL;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 11'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d     = 11'd0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          v_cnt_d = v_cnt_q + 11'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_px or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q     <= 11'd0;
      v_cnt_q     <= 11'd0;
      frame_cnt_q <= 8'd0;
      pattern_q   <= 2'd0;
      de_q        <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      x_q         <= 11'd0;
      y_q         <= 11'd0;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
      pixel_q     <= 24'h000000;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pattern_q   <= pattern_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      x_q         <= x_d;
      y_q         <= y_d;
      new_line_q  <= new_line_d;
      new_frame_q <= new_frame_d;
      pixel_q     <= pixel_d;
    end
  end

  assign vid.de        = de_q;
  assign vid.hsync     = hsync_q;
  assign vid.vsync     = vsync_q;
  assign vid.x         = x_q;
  assign vid.y         = y_q;
  assign vid.new_line  = new_line_q;
  assign vid.new_frame = new_frame_q;
  assign vid.pixel     = pixel_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster (80x46 totals) so several frames fit in a short run.
// A reference model pushes the expected outputs each clock; scenario tasks pop and compare them.
module tb_video_timing_gen;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VS = 3, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int BW = HA / 8;
  localparam bit SYNC_POL = 1'b0;

  typedef struct packed {
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [10:0] x;
    logic [10:0] y;
    logic        new_line;
    logic        new_frame;
    logic [23:0] pixel;
  } exp_t;

  logic       clk_px = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;

  int errors = 0;
  int checks = 0;

  exp_t sb_q[$];
  int   m_h, m_v, m_f, m_pat;

  video_timing_gen_if vif();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .clk_px     (clk_px),
    .reset_n    (reset_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .vid        (vif)
  );

  always #5 clk_px = ~clk_px;

  function automatic logic [23:0] model_pixel(int pat, int xx, int yy, int fc);
    logic [23:0] p;
    p = 24'h000000;
    case (pat)
      0: case (xx / BW)
           0: p = 24'hFFFFFF;
           1: p = 24'hFFFF00;
           2: p = 24'h00FFFF;
           3: p = 24'h00FF00;
           4: p = 24'hFF00FF;
           5: p = 24'hFF0000;
           6: p = 24'h0000FF;
           default: p = 24'h000000;
         endcase
      1: p = {8'(xx % 256), 8'(yy % 256), 8'((xx ^ yy) % 256)};
      2: p = (((xx / 32) + (yy / 32)) % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
      default: p = {16'h0000, 8'(fc % 256)};
    endcase
    return p;
  endfunction

  // Reference raster: what the DUT must show one cycle after each clock edge.
  always @(posedge clk_px or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      m_h = 0; m_v = 0; m_f = 0; m_pat = 0;
      sb_q.delete();
    end else begin
      e = '0;
      e.hsync = ~SYNC_POL;
      e.vsync = ~SYNC_POL;
      if (enable) begin
        if (m_h == 0 && m_v == 0) m_pat = int'(pattern_sel);
        if (m_h < HA && m_v < VA) begin
          e.de       = 1'b1;
          e.x        = 11'(m_h);
          e.y        = 11'(m_v);
          e.pixel    = model_pixel(m_pat, m_h, m_v, m_f);
          e.new_line = (m_h == 0);
        end
        e.new_frame = (m_h == 0 && m_v == 0);
        if (m_h >= HA + HFP && m_h < HA + HFP + HS) e.hsync = SYNC_POL;
        if (m_v >= VA + VFP && m_v < VA + VFP + VS) e.vsync = SYNC_POL;
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) begin
            m_v = 0;
            m_f = (m_f + 1) % 256;
          end
        end
      end else begin
        m_h = 0; m_v = 0; m_f = 0;
      end
      sb_q.push_back(e);
    end
  end

  task automatic next_cycle(output exp_t e);
    @(negedge clk_px);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e = '0;
      e.hsync = ~SYNC_POL;
      e.vsync = ~SYNC_POL;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
    repeat (3) @(negedge clk_px);
    checks++; if (vif.de !== 1'b0) begin errors++; $display("[TB] FAIL reset_de got=%0b exp=0", vif.de); end
    checks++; if (vif.hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync got=%0b exp=1", vif.hsync); end
    checks++; if (vif.vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync got=%0b exp=1", vif.vsync); end
    checks++; if ({vif.x, vif.y} !== 22'd0) begin errors++; $display("[TB] FAIL reset_xy got=%0d,%0d exp=0,0", vif.x, vif.y); end
    checks++; if (vif.pixel !== 24'h0) begin errors++; $display("[TB] FAIL reset_pixel got=%06h exp=000000", vif.pixel); end
    checks++; if ({vif.new_line, vif.new_frame} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes got=%b exp=00", {vif.new_line, vif.new_frame}); end
    reset_n = 1'b1;
    next_cycle(e);
    checks++; if (vif.de !== 1'b1) begin errors++; $display("[TB] FAIL start_de got=%0b exp=1", vif.de); end
    checks++; if (vif.new_frame !== 1'b1) begin errors++; $display("[TB] FAIL start_new_frame got=%0b exp=1", vif.new_frame); end
    checks++; if (vif.new_line !== 1'b1) begin errors++; $display("[TB] FAIL start_new_line got=%0b exp=1", vif.new_line); end
    checks++; if ({vif.x, vif.y} !== 22'd0) begin errors++; $display("[TB] FAIL start_xy got=%0d,%0d exp=0,0", vif.x, vif.y); end
    checks++; if (vif.pixel !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL start_pixel got=%06h exp=FFFFFF", vif.pixel); end
  endtask

  task automatic test_horizontal();
    exp_t e;
    int de_cnt, hs_cnt, hs_first, nl_next;
    de_cnt = 1; hs_cnt = 0; hs_first = -1; nl_next = -1;
    for (int t = 1; t <= HT; t++) begin
      next_cycle(e);
      checks++;
      if (vif.de !== e.de || vif.hsync !== e.hsync || vif.x !== e.x) begin
        errors++;
        $display("[TB] FAIL h_cycle t=%0d got de=%0b hs=%0b x=%0d exp de=%0b hs=%0b x=%0d", t, vif.de, vif.hsync, vif.x, e.de, e.hsync, e.x);
      end
      if (t < HT) begin
        if (vif.de === 1'b1) de_cnt++;
        if (vif.hsync === SYNC_POL) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = t;
        end
      end
      if (vif.new_line === 1'b1 && nl_next < 0) nl_next = t;
    end
    checks++; if (de_cnt != HA) begin errors++; $display("[TB] FAIL de_width got=%0d exp=%0d", de_cnt, HA); end
    checks++; if (hs_cnt != HS) begin errors++; $display("[TB] FAIL hsync_width got=%0d exp=%0d", hs_cnt, HS); end
    checks++; if (hs_first != HA + HFP) begin errors++; $display("[TB] FAIL hsync_start got=%0d exp=%0d", hs_first, HA + HFP); end
    checks++; if (nl_next != HT) begin errors++; $display("[TB] FAIL line_period got=%0d exp=%0d", nl_next, HT); end
  endtask

  task automatic test_vertical();
    exp_t e;
    bit found;
    int nl_cnt, vs_cnt, vs_first, period;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      next_cycle(e);
      if (vif.new_frame === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL frame_align got=timeout exp=new_frame"); end
    nl_cnt = (vif.new_line === 1'b1) ? 1 : 0;
    vs_cnt = 0; vs_first = -1; period = -1;
    for (int i = 1; i <= FRAME; i++) begin
      next_cycle(e);
      checks++;
      if (vif.vsync !== e.vsync || vif.new_line !== e.new_line || vif.new_frame !== e.new_frame || vif.y !== e.y) begin
        errors++;
        $display("[TB] FAIL v_cycle i=%0d got vs=%0b nl=%0b nf=%0b y=%0d exp vs=%0b nl=%0b nf=%0b y=%0d", i, vif.vsync, vif.new_line, vif.new_frame, vif.y, e.vsync, e.new_line, e.new_frame, e.y);
      end
      if (i < FRAME) begin
        if (vif.new_line === 1'b1) nl_cnt++;
        if (vif.vsync === SYNC_POL) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = i;
        end
      end
      if (vif.new_frame === 1'b1 && period < 0) period = i;
    end
    checks++; if (nl_cnt != VA) begin errors++; $display("[TB] FAIL new_line_count got=%0d exp=%0d", nl_cnt, VA); end
    checks++; if (vs_cnt != VS * HT) begin errors++; $display("[TB] FAIL vsync_width got=%0d exp=%0d", vs_cnt, VS * HT); end
    checks++; if (vs_first != (VA + VFP) * HT) begin errors++; $display("[TB] FAIL vsync_start got=%0d exp=%0d", vs_first, (VA + VFP) * HT); end
    checks++; if (period != FRAME) begin errors++; $display("[TB] FAIL frame_period got=%0d exp=%0d", period, FRAME); end
  endtask

  task automatic test_colour_bars();
    exp_t e;
    for (int i = 1; i <= FRAME; i++) begin
      next_cycle(e);
      checks++; if (vif.pixel !== e.pixel) begin errors++; $display("[TB] FAIL bars_pixel x=%0d y=%0d got=%06h exp=%06h", e.x, e.y, vif.pixel, e.pixel); end
      if (vif.de === 1'b0) begin
        checks++; if (vif.pixel !== 24'h0) begin errors++; $display("[TB] FAIL blank_pixel got=%06h exp=000000", vif.pixel); end
      end
      if (e.de && e.x == 11'd0) begin
        checks++; if (vif.pixel !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL bar0 got=%06h exp=FFFFFF", vif.pixel); end
      end
      if (e.de && e.x == 11'(BW)) begin
        checks++; if (vif.pixel !== 24'hFFFF00) begin errors++; $display("[TB] FAIL bar1 got=%06h exp=FFFF00", vif.pixel); end
      end
      if (e.de && e.x == 11'(2 * BW)) begin
        checks++; if (vif.pixel !== 24'h00FFFF) begin errors++; $display("[TB] FAIL bar2 got=%06h exp=00FFFF", vif.pixel); end
      end
      if (e.de && e.x == 11'(HA - 1)) begin
        checks++; if (vif.pixel !== 24'h000000) begin errors++; $display("[TB] FAIL bar7 got=%06h exp=000000", vif.pixel); end
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      next_cycle(e);
      if (e.de && e.x == 11'd30 && e.y == 11'd20) found = 1'b1;
    end
    checks++; if (!found || vif.x !== 11'd30 || vif.y !== 11'd20) begin errors++; $display("[TB] FAIL enable_pos got=%0d,%0d exp=30,20", vif.x, vif.y); end
    enable = 1'b0;
    next_cycle(e);
    checks++; if (vif.de !== 1'b0) begin errors++; $display("[TB] FAIL disable_de got=%0b exp=0", vif.de); end
    checks++; if ({vif.hsync, vif.vsync} !== {~SYNC_POL, ~SYNC_POL}) begin errors++; $display("[TB] FAIL disable_syncs got=%b exp=11", {vif.hsync, vif.vsync}); end
    checks++; if ({vif.x, vif.y, vif.pixel} !== 46'd0) begin errors++; $display("[TB] FAIL disable_data got=%0d,%0d,%06h exp=0,0,000000", vif.x, vif.y, vif.pixel); end
    repeat (3) begin
      next_cycle(e);
      checks++; if (vif.de !== e.de || vif.new_frame !== e.new_frame) begin errors++; $display("[TB] FAIL idle_de got=%0b exp=%0b", vif.de, e.de); end
    end
    enable = 1'b1;
    next_cycle(e);
    checks++; if (vif.new_frame !== 1'b1) begin errors++; $display("[TB] FAIL restart_new_frame got=%0b exp=1", vif.new_frame); end
    checks++; if ({vif.x, vif.y} !== 22'd0 || vif.de !== 1'b1) begin errors++; $display("[TB] FAIL restart_pos got=%0d,%0d de=%0b exp=0,0 de=1", vif.x, vif.y, vif.de); end
  endtask

  task automatic test_pattern_latch();
    exp_t e;
    int fidx;
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      next_cycle(e);
      if (e.de && e.x == 11'd0 && e.y == 11'd20) found = 1'b1;
    end
    pattern_sel = 2'd3;
    fidx = 0;
    for (int i = 0; i < 4 * FRAME && fidx < 3; i++) begin
      next_cycle(e);
      if (e.new_frame) fidx++;
      if (e.de && fidx < 3) begin
        checks++; if (vif.pixel !== e.pixel) begin errors++; $display("[TB] FAIL latch_pixel f=%0d x=%0d y=%0d got=%06h exp=%06h", fidx, e.x, e.y, vif.pixel, e.pixel); end
        if (fidx == 0 && e.x == 11'd0) begin
          checks++; if (vif.pixel !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL bars_persist got=%06h exp=FFFFFF", vif.pixel); end
        end
        if (fidx == 1) begin
          checks++; if (vif.pixel !== 24'h000001) begin errors++; $display("[TB] FAIL fill_frame1 got=%06h exp=000001", vif.pixel); end
        end
        if (fidx == 2) begin
          checks++; if (vif.pixel !== 24'h000002) begin errors++; $display("[TB] FAIL fill_frame2 got=%06h exp=000002", vif.pixel); end
        end
      end
    end
    checks++; if (!found || fidx != 3) begin errors++; $display("[TB] FAIL latch_frames got=%0d exp=3", fidx); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int fidx;
    pattern_sel = 2'd1;
    fidx = 0;
    for (int i = 0; i < 4 * FRAME && fidx < 3; i++) begin
      next_cycle(e);
      if (e.new_frame) begin
        fidx++;
        if (fidx == 1) pattern_sel = 2'd2;
      end
      if (e.de && fidx < 3) begin
        checks++; if (vif.pixel !== e.pixel) begin errors++; $display("[TB] FAIL b2b_pixel f=%0d x=%0d y=%0d got=%06h exp=%06h", fidx, e.x, e.y, vif.pixel, e.pixel); end
        if (fidx == 0 && e.x == 11'd10) begin
          checks++; if (vif.pixel !== 24'h000003) begin errors++; $display("[TB] FAIL fill_frame3 got=%06h exp=000003", vif.pixel); end
        end
        if (fidx == 1 && e.x == 11'd5 && e.y == 11'd3) begin
          checks++; if (vif.pixel !== 24'h050306) begin errors++; $display("[TB] FAIL gradient got=%06h exp=050306", vif.pixel); end
        end
        if (fidx == 2 && e.x == 11'd33 && e.y == 11'd0) begin
          checks++; if (vif.pixel !== 24'h000000) begin errors++; $display("[TB] FAIL checker_dark got=%06h exp=000000", vif.pixel); end
        end
        if (fidx == 2 && e.x == 11'd33 && e.y == 11'd33) begin
          checks++; if (vif.pixel !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL checker_light got=%06h exp=FFFFFF", vif.pixel); end
        end
      end
    end
    checks++; if (fidx != 3) begin errors++; $display("[TB] FAIL b2b_frames got=%0d exp=3", fidx); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    repeat (100) next_cycle(e);
    checks++; if (vif.de !== 1'b1 || vif.x !== e.x) begin errors++; $display("[TB] FAIL pre_reset got de=%0b x=%0d exp de=1 x=%0d", vif.de, vif.x, e.x); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (vif.de !== 1'b0) begin errors++; $display("[TB] FAIL async_de got=%0b exp=0", vif.de); end
    checks++; if ({vif.hsync, vif.vsync} !== 2'b11) begin errors++; $display("[TB] FAIL async_syncs got=%b exp=11", {vif.hsync, vif.vsync}); end
    checks++; if ({vif.x, vif.y, vif.pixel} !== 46'd0) begin errors++; $display("[TB] FAIL async_data got=%0d,%0d,%06h exp=0,0,000000", vif.x, vif.y, vif.pixel); end
    @(negedge clk_px);
    reset_n = 1'b1;
    next_cycle(e);
    checks++; if (vif.new_frame !== 1'b1 || vif.de !== 1'b1) begin errors++; $display("[TB] FAIL post_reset got nf=%0b de=%0b exp nf=1 de=1", vif.new_frame, vif.de); end
    checks++; if (vif.pixel !== e.pixel) begin errors++; $display("[TB] FAIL post_reset_pixel got=%06h exp=%06h", vif.pixel, e.pixel); end
  endtask

  initial begin
    #(80000 * 10);
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_colour_bars();
    test_enable();
    test_pattern_latch();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Pixel-clock video timing and test-pattern generator. It sits directly upstream of the TMDS encoder stage and produces the 24-bit RGB pixel plus the de/hsync/vsync controls that the encoder consumes. It also produces x/y coordinates and line/frame strobes. Defaults give 640x480@60 Hz timing on the 25 MHz pixel clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line; must be divisible by 8
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk_px  in  1  pixel clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run when high; when low, hold in idle
- pattern_sel  in  2  pattern select, sampled at frame start
- de  out  1  data enable, high in the active region
- hsync  out  1  horizontal sync, level SYNC_POL when asserted
- vsync  out  1  vertical sync, level SYNC_POL when asserted
- x  out  11  active-pixel column; 0 when de=0
- y  out  11  active line; 0 when de=0
- new_line  out  1  one-cycle pulse on the first active pixel of each active line
- new_frame  out  1  one-cycle pulse on pixel (0,0) of each frame
- pixel  out  24  {R[7:0],G[7:0],B[7:0]}; 0 when de=0

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt advances only when h_cnt wraps. It counts 0..V_TOTAL-1 and wraps to 0.
- Regions:
  - Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync asserted: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
  - vsync asserted: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [490,492), for whole lines.
- 8-bit frame counter increments when v_cnt wraps, and wraps 255->0.
- Pattern register:
  - Loads pattern_sel on the cycle h_cnt=0 and v_cnt=0, and at the enable rising edge.
  - A change to pattern_sel mid-frame has no effect until the next frame.
- Patterns, evaluated on active pixels:
  - 0: colour bars, 8 bars of width H_ACTIVE/8, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 1: gradient. R=x[7:0], G=y[7:0], B=(x^y)[7:0].
  - 2: checkerboard, 32-pixel squares. FFFFFF when x[5]^y[5]=0, else 000000.
  - 3: frame-count fill. {8'h00, 8'h00, frame_cnt}.
- Enable:
  - enable low: h_cnt, v_cnt and frame_cnt are synchronously cleared, and all outputs are driven to their reset values.
  - Deassert mid-line: blanks the outputs on the next cycle.
  - Reassert: restarts at pixel (0,0), and new_frame is emitted.

## Timing
- All outputs are registered. Counter state at cycle n appears on the outputs at cycle n+1, so latency is 1 cycle.
- de, x, y, pixel, hsync, vsync, new_line and new_frame are mutually aligned in the same cycle.
- Reset (reset_n low, asynchronous), output values:
  - de=0, new_line=0, new_frame=0
  - hsync=vsync=~SYNC_POL
  - x=0, y=0, pixel=0
  - counters=0, pattern register=0
- Leaving reset with enable high: first output cycle is pixel (0,0), with de=1 and new_frame=1.
- Reset asserted mid-frame: outputs are forced to reset values immediately, without waiting for a clock edge.
- Line period is exactly H_TOTAL cycles. Frame period is exactly H_TOTAL*V_TOTAL cycles (420000).
- new_line also fires on line 0, in the same cycle as new_frame.
- No new_line pulse on blanking lines.

## Test plan
- Reset and start:
  - Hold reset_n low with enable=1, then release.
  - Required: outputs at reset values during reset, hsync=vsync=1.
  - Required: the cycle after first output, de=1, new_frame=1, new_line=1, x=0, y=0.
- Horizontal timing:
  - Required: de high for 640 cycles, then low for 160.
  - Required: hsync low for exactly 96 cycles, starting 656 cycles after de rises.
  - Required: line period 800 cycles.
- Vertical timing:
  - Required: vsync low for 1600 cycles, starting 490*800 cycles after new_frame.
  - Required: 480 new_line pulses per frame.
  - Required: new_frame period 420000 cycles.
- Colour bars (pattern_sel=0):
  - Required: pixel=FFFFFF at x=0, FFFF00 at x=80, 00FFFF at x=160, 000000 at x=639.
  - Required: pixel=0 whenever de=0.
- Pattern latch and fill:
  - Change pattern_sel 0->3 at y=100.
  - Required: bars persist for the rest of that frame.
  - Required: the next frame shows pixel=000001 (frame_cnt=1).
  - Required: the frame after that shows 000002.
- Enable and reset mid-operation:
  - Drop enable at x=300, y=200.
  - Required: the next cycle shows de=0 and syncs inactive.
  - Reassert enable. Required: new_frame with x=0, y=0 one cycle later.
  - Pulse reset_n mid-frame. Required: outputs clear asynchronously.
